// File: rtl/cpen391_target_coord_out.sv
// Avalon-MM output port: CPU-written coordinate words are queued in a small FIFO
// and presented to a fabric consumer over a valid/ready stream.
module cpen391_target_coord_out #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr, rd_next, wr_next;
  logic [LW-1:0]         level, level_next;
  logic                  enable, enable_next, overflow;
  logic [DATA_WIDTH-1:0] last_wr, head_next, rd_mux;
  logic                  wr, push_req, push, pop, flush, full, empty, valid_next;

  assign wr        = chipselect & ~write_n;
  assign push_req  = wr && (address == 2'd0);
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign push      = push_req & ~full;
  assign flush     = wr && (address == 2'd2) && writedata[1];
  assign pop       = out_valid & out_ready & ~flush;
  assign out_valid = enable & ~empty;

  always_comb begin
    rd_next     = rd_ptr;
    wr_next     = wr_ptr;
    level_next  = level;
    enable_next = enable;
    if (wr && (address == 2'd2))
      enable_next = writedata[0];
    if (flush) begin
      rd_next    = wr_ptr;
      level_next = '0;
    end else begin
      if (push) wr_next = wr_ptr + AW'(1);
      if (pop)  rd_next = rd_ptr + AW'(1);
      if (push && !pop)
        level_next = level + LW'(1);
      else if (pop && !push)
        level_next = level - LW'(1);
    end
    // out_data is a register so it can hold while out_valid is low; this
    // forwards a word being pushed into the slot that becomes the head.
    head_next  = (push && (rd_next == wr_ptr)) ? writedata : mem[rd_next];
    valid_next = enable_next && (level_next != '0);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux = last_wr;
      2'd1: begin
        rd_mux[0]    = empty;
        rd_mux[1]    = full;
        rd_mux[2]    = overflow;
        rd_mux[15:8] = 8'(level);
      end
      2'd2: rd_mux[0] = enable;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      enable   <= 1'b0;
      overflow <= 1'b0;
      last_wr  <= '0;
      readdata <= '0;
      out_data <= '0;
    end else begin
      if (push)
        mem[wr_ptr] <= writedata;
      rd_ptr   <= rd_next;
      wr_ptr   <= wr_next;
      level    <= level_next;
      enable   <= enable_next;
      readdata <= rd_mux;
      if (push_req)
        last_wr <= writedata;
      if (push_req && full)
        overflow <= 1'b1;
      else if (wr && (address == 2'd1) && writedata[2])
        overflow <= 1'b0;
      if (valid_next)
        out_data <= head_next;
    end
  end

endmodule

// File: tb/tb_cpen391_target_coord_out.sv
// Scoreboard bench for cpen391_target_coord_out: directed register-map scenarios
// followed by randomized bus/consumer traffic against a queue-based model.
module tb_cpen391_target_coord_out;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  cpen391_target_coord_out #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO contents are the scoreboard queue.
  logic [31:0] exp_q[$];
  bit          m_en, m_ovf;
  logic [31:0] m_last, exp_rd, nxt_rd;
  int          sz;
  bit          m_wr, m_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1, so at negedge they describe the coming edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_en   = 1'b0;
      m_ovf  = 1'b0;
      m_last = '0;
      exp_rd = '0;
    end else begin
      sz = exp_q.size();
      chk("readdata", readdata, exp_rd);
      chk("out_valid", {31'b0, out_valid}, {31'b0, (m_en && sz != 0)});
      m_wr    = chipselect && !write_n;
      m_flush = m_wr && (address == 2'd2) && writedata[1];
      case (address)
        2'd0:    nxt_rd = m_last;
        2'd1:    nxt_rd = (sz << 8) | (m_ovf ? 4 : 0) | (sz == DEPTH ? 2 : 0) | (sz == 0 ? 1 : 0);
        2'd2:    nxt_rd = {31'b0, m_en};
        default: nxt_rd = '0;
      endcase
      exp_rd = nxt_rd;
      if (m_en && sz != 0 && out_ready && !m_flush) begin
        chk("out_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (m_wr) begin
        case (address)
          2'd0: begin
            m_last = writedata;
            if (sz == DEPTH) m_ovf = 1'b1;
            else exp_q.push_back(writedata);
          end
          2'd1: if (writedata[2]) m_ovf = 1'b0;
          2'd2: begin
            m_en = writedata[0];
            if (writedata[1]) exp_q.delete();
          end
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_const(input logic [1:0] a, input logic [31:0] exp, input string name);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
    chk(name, readdata, exp);
  endtask

  int r;
  int n;

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    rd_const(2'd0, 32'h0, "rst_data");
    rd_const(2'd1, 32'h1, "rst_status");
    rd_const(2'd2, 32'h0, "rst_ctrl");
    rd_const(2'd3, 32'h0, "rst_addr3");
    chk("rst_valid", {31'b0, out_valid}, 32'h0);

    bus_wr(2'd2, 32'h1);
    bus_wr(2'd0, 32'h00120034);
    bus_wr(2'd0, 32'h00560078);
    chk("two_valid", {31'b0, out_valid}, 32'h1);
    chk("two_head", out_data, 32'h00120034);
    rd_const(2'd1, 32'h00000200, "two_status");
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("two_drained", {31'b0, out_valid}, 32'h0);
    rd_const(2'd1, 32'h00000001, "two_empty");

    bus_wr(2'd2, 32'h0);
    for (int i = 1; i <= 5; i++) bus_wr(2'd0, i);
    rd_const(2'd1, 32'h00000406, "ovf_status");
    out_ready = 1'b1;
    bus_wr(2'd2, 32'h1);
    repeat (4) tick();
    chk("ovf_drained", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;
    rd_const(2'd0, 32'h5, "ovf_last");

    bus_wr(2'd1, 32'h4);
    for (int i = 0; i < 4; i++) bus_wr(2'd0, 32'hA0 + i);
    out_ready = 1'b1;
    bus_wr(2'd0, 32'hBB);
    out_ready = 1'b0;
    rd_const(2'd1, 32'h00000304, "fullpop_status");
    bus_wr(2'd1, 32'h4);
    rd_const(2'd1, 32'h00000300, "ovf_clear");

    out_ready = 1'b1;
    bus_wr(2'd2, 32'h3);
    out_ready = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    rd_const(2'd2, 32'h1, "flush_ctrl");
    rd_const(2'd1, 32'h1, "flush_status");

    bus_wr(2'd0, 32'h11);
    bus_wr(2'd0, 32'h22);
    out_ready = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    rd_const(2'd1, 32'h1, "post_rst_status");
    rd_const(2'd2, 32'h0, "post_rst_ctrl");

    for (int i = 0; i < 800; i++) begin
      r          = $urandom_range(0, 9);
      out_ready  = ($urandom_range(0, 2) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      chipselect = 1'b1;
      write_n    = 1'b0;
      case (r)
        0, 1, 2, 3: address = 2'd0;
        4: address = 2'd1;
        5: begin
          address      = 2'd2;
          writedata[0] = ($urandom_range(0, 4) != 0);
          writedata[1] = ($urandom_range(0, 7) == 0);
        end
        6: address = 2'd3;
        7: chipselect = 1'b0;
        default: write_n = 1'b1;
      endcase
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    bus_wr(2'd2, 32'h1);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
